fifo_fwft_bram: RTL

//  Parametrised BRAM-backed FIFO with first-word-fall-through (FWFT) output.

---
 rtl/fifo_fwft_bram.sv | 113 +++++++++++
 1 files changed

// File: rtl/fifo_fwft_bram.sv
// BRAM-backed FIFO with first-word-fall-through output, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_fwft_bram #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 5,
  parameter int W_CNT    = 3,
  parameter int W_POS    = 3,
  parameter int AF_LEVEL = 4,
  parameter int AE_LEVEL = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENQ,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DEQ,
  output logic [WIDTH-1:0] DOUT,
  output logic             EMPTY,
  output logic             FULL,
  output logic             ALMOST_FULL,
  output logic             ALMOST_EMPTY,
  output logic [W_CNT-1:0] CNT,
  output logic             OVF,
  output logic             UDF
);

  localparam logic [W_CNT-1:0] L_DEPTH = W_CNT'(DEPTH);
  localparam logic [W_CNT-1:0] L_AF    = W_CNT'(AF_LEVEL);
  localparam logic [W_CNT-1:0] L_AE    = W_CNT'(AE_LEVEL);
  localparam logic [W_POS-1:0] L_LAST  = W_POS'(DEPTH - 1);
  localparam logic [W_CNT-1:0] L_ONE   = W_CNT'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [W_POS-1:0] r_wptr;
  logic [W_POS-1:0] r_hptr;
  logic [W_CNT-1:0] r_ram_cnt;
  logic [W_CNT-1:0] r_cnt;
  logic             r_rd_vld;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_out_vld;
  logic [WIDTH-1:0] r_out_data;
  logic             r_ovf;
  logic             r_udf;

  logic w_full;
  logic w_we;
  logic w_re;
  logic w_move;
  logic w_issue;

  assign w_full  = (r_cnt == L_DEPTH);
  assign w_we    = ENQ & ~w_full & ~RST;
  assign w_re    = DEQ & r_out_vld & ~RST;
  // Read stage hands over when the output register is free or being popped.
  assign w_move  = r_rd_vld & (~r_out_vld | w_re);
  assign w_issue = (r_ram_cnt != '0) & (~r_rd_vld | w_move) & ~RST;

  always_ff @(posedge CLK) begin
    if (w_we) r_mem[r_wptr] <= DIN;
    if (w_issue) r_rd_data <= r_mem[r_hptr];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wptr     <= '0;
      r_hptr     <= '0;
      r_ram_cnt  <= '0;
      r_cnt      <= '0;
      r_rd_vld   <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      if (w_we)
        r_wptr <= (r_wptr == L_LAST) ? '0 : r_wptr + 1'b1;
      if (w_issue)
        r_hptr <= (r_hptr == L_LAST) ? '0 : r_hptr + 1'b1;
      if (w_we & ~w_issue)
        r_ram_cnt <= r_ram_cnt + L_ONE;
      else if (~w_we & w_issue)
        r_ram_cnt <= r_ram_cnt - L_ONE;
      if (w_we & ~w_re)
        r_cnt <= r_cnt + L_ONE;
      else if (~w_we & w_re)
        r_cnt <= r_cnt - L_ONE;
      if (w_issue)
        r_rd_vld <= 1'b1;
      else if (w_move)
        r_rd_vld <= 1'b0;
      if (w_move) begin
        r_out_vld  <= 1'b1;
        r_out_data <= r_rd_data;
      end else if (w_re) begin
        r_out_vld  <= 1'b0;
        r_out_data <= '0;
      end
      if (ENQ & w_full)
        r_ovf <= 1'b1;
      if (DEQ & ~r_out_vld)
        r_udf <= 1'b1;
    end
  end

  assign DOUT         = r_out_data;
  assign EMPTY        = ~r_out_vld;
  assign FULL         = w_full;
  assign ALMOST_FULL  = (r_cnt >= L_AF);
  assign ALMOST_EMPTY = (r_cnt <= L_AE);
  assign CNT          = r_cnt;
  assign OVF          = r_ovf;
  assign UDF          = r_udf;

endmodule
